// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared widths, write-enable encodings and helpers for the register-file write arbiter.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package regfile_wr_arbiter_pkg;

  localparam int REG_BUS_W   = 32;  // register data width
  localparam int REG_ADDR_W  = 5;   // register address width
  localparam int WB_REQ_NUM  = 2;   // default number of writeback requesters
  localparam int CONFLICT_W  = 16;  // default conflict counter width
  localparam int MAX_REQ     = 8;   // widest requester vector the helpers accept

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  // True when two or more bits of v are set (clearing the lowest set bit leaves something).
  function automatic logic multi_hot(input logic [MAX_REQ-1:0] v);
    return (v & (v - MAX_REQ'(1))) != '0;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Round-robin priority encoder: first set request strictly after ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; gnt is zero when no request is set.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Scan N positions starting one past the pointer; the first hit wins.
  always_comb begin : pick
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = PW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between NREQ writeback requesters, round-robin.
// Latency: grant is same-cycle; accepted write appears on we/waddr/wdata one cycle later.
// Backpressure: valid/ready per requester; wb_en=0 withholds every ready.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NREQ = WB_REQ_NUM,
  parameter int AW   = REG_ADDR_W,
  parameter int DW   = REG_BUS_W,
  parameter int CW   = CONFLICT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_en,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               we,
  output logic [AW-1:0]      waddr,
  output logic [DW-1:0]      wdata,
  output logic [CW-1:0]      conflict_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Pointer starts at the last requester so requester 0 is searched first.
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               we_q, we_d;
  logic [AW-1:0]      waddr_q, waddr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [NREQ-1:0]    req_live;
  logic [NREQ-1:0]    gnt;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;
  logic [MAX_REQ-1:0] valid_ext;
  logic               conflict;

  // Masking requests with wb_en makes the disabled case fall out of the picker.
  assign req_live = wb_en ? req_valid : '0;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req (req_live),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign req_ready = gnt;

  // One-hot mux of the winner's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // A conflict is any enabled cycle with two or more requesters valid.
  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = req_valid;
    conflict              = wb_en && multi_hot(valid_ext);
  end

  // Next state: capture the winner, suppress r0 writes, hold address/data when idle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we_d     = WRITE_DISABLE;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    if (gnt_any) begin
      rr_ptr_d = gnt_idx;
      waddr_d  = sel_addr;
      wdata_d  = sel_data;
      we_d     = (sel_addr != '0) ? WRITE_ENABLE : WRITE_DISABLE;
    end
    if (conflict && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers; reset discards any registered write in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= PTR_RST;
      we_q     <= WRITE_DISABLE;
      waddr_q  <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign we           = we_q;
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter with three requesters and a 4-bit conflict counter.
// Latency: checks same-cycle grant and one-cycle registered write.
// Backpressure: random requesters hold valid/addr/data until granted.
module tb_regfile_wr_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk;
  logic            rst;
  logic            wb_en;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [CW-1:0]   conflict_cnt;

  regfile_wr_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_en        (wb_en),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: last winner, registered write, counter and a register file.
  int           m_last;
  logic         m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int           m_cnt;
  logic [N-1:0] m_gnt;
  logic [DW-1:0] rf [32];

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (wb_en && req_valid != '0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (g == '0 && req_valid[j]) g[j] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_last  = N - 1;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_cnt   = 0;
    m_gnt   = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Advance one clock edge, update the model, and leave inputs 1 ns past the edge.
  task automatic cycle();
    logic [N-1:0] g;
    int pop;
    g   = model_grant();
    pop = $countones(req_valid);
    @(posedge clk);
    if (m_we) rf[m_waddr] = m_wdata;
    m_gnt = g;
    if (g != '0) begin
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          m_last  = i;
          m_waddr = req_addr[i*AW +: AW];
          m_wdata = req_data[i*DW +: DW];
          m_we    = (m_waddr != 0);
        end
      end
    end else begin
      m_we = 1'b0;
    end
    if (wb_en && pop >= 2 && m_cnt < CMAX) m_cnt++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    #3;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    wb_en     = 1'b1;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    do_reset();
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b want=0", we); end
    n_cmp++; if (waddr !== '0) begin n_bad++; $display("FAIL reset_waddr got=%0d want=0", waddr); end
    n_cmp++; if (wdata !== '0) begin n_bad++; $display("FAIL reset_wdata got=%h want=0", wdata); end
    n_cmp++; if (conflict_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt got=%0d want=0", conflict_cnt); end
    n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL reset_ready got=%b want=0", req_ready); end
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL single_ready got=%b want=001", req_ready); end
    cycle();
    req_valid = '0;
    n_cmp++; if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL single_write got=%b/%0d/%h want=1/5/deadbeef", we, waddr, wdata);
    end
    cycle();
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL single_we_drop got=%b want=0", we); end
    n_cmp++; if (rf[5] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_rf got=%h want=deadbeef", rf[5]); end
  endtask

  task automatic test_contention();
    logic [N-1:0] want;
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    for (int k = 0; k < 4; k++) begin
      want = (k % 2 == 0) ? 3'b001 : 3'b010;
      #1;
      n_cmp++; if (req_ready !== want || req_ready !== model_grant()) begin
        n_bad++; $display("FAIL contend_ready[%0d] got=%b want=%b", k, req_ready, want);
      end
      cycle();
      n_cmp++; if (we !== 1'b1 || waddr !== ((k % 2 == 0) ? 5'd1 : 5'd2) || wdata !== m_wdata) begin
        n_bad++; $display("FAIL contend_write[%0d] got=%b/%0d/%h want=1/%0d/%h", k, we, waddr, wdata, m_waddr, m_wdata);
      end
    end
    n_cmp++; if (conflict_cnt !== 4'd4) begin n_bad++; $display("FAIL contend_cnt got=%0d want=4", conflict_cnt); end
    req_valid = '0;
  endtask

  task automatic test_r0();
    set_req(1, 1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL r0_ready got=%b want=010", req_ready); end
    cycle();
    req_valid = '0;
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL r0_we got=%b want=0", we); end
    n_cmp++; if (waddr !== 5'd0 || wdata !== 32'hFFFFFFFF) begin
      n_bad++; $display("FAIL r0_regs got=%0d/%h want=0/ffffffff", waddr, wdata);
    end
    cycle();
    n_cmp++; if (rf[0] !== '0) begin n_bad++; $display("FAIL r0_rf got=%h want=0", rf[0]); end
    n_cmp++; if (waddr !== 5'd0 || wdata !== 32'hFFFFFFFF) begin
      n_bad++; $display("FAIL r0_hold got=%0d/%h want=0/ffffffff", waddr, wdata);
    end
  endtask

  task automatic test_wb_en();
    logic [CW-1:0] c0;
    logic [N-1:0]  want;
    c0 = conflict_cnt;
    wb_en = 1'b0;
    set_req(0, 1'b1, 5'd9, 32'h99);
    set_req(1, 1'b1, 5'd10, 32'hAA);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL wben_ready[%0d] got=%b want=000", k, req_ready); end
      cycle();
      n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL wben_we[%0d] got=%b want=0", k, we); end
    end
    n_cmp++; if (conflict_cnt !== c0) begin n_bad++; $display("FAIL wben_cnt got=%0d want=%0d", conflict_cnt, c0); end
    wb_en = 1'b1;
    want = '0;
    want[(m_last + 1) % N] = 1'b1;
    if (!req_valid[(m_last + 1) % N]) want = model_grant();
    #1;
    n_cmp++; if (req_ready !== want) begin n_bad++; $display("FAIL wben_regrant got=%b want=%b", req_ready, want); end
    cycle();
    req_valid = '0;
    n_cmp++; if (we !== m_we || waddr !== m_waddr || wdata !== m_wdata) begin
      n_bad++; $display("FAIL wben_write got=%b/%0d/%h want=%b/%0d/%h", we, waddr, wdata, m_we, m_waddr, m_wdata);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(0, 1'b1, 5'd7, 32'h77);
    set_req(1, 1'b1, 5'd8, 32'h88);
    cycle();
    cycle();
    n_cmp++; if (we !== 1'b1 || conflict_cnt !== 4'd2) begin
      n_bad++; $display("FAIL areset_pre got=%b/%0d want=1/2", we, conflict_cnt);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (we !== 1'b0 || waddr !== '0 || wdata !== '0 || conflict_cnt !== '0) begin
      n_bad++; $display("FAIL areset_now got=%b/%0d/%h/%0d want=0/0/0/0", we, waddr, wdata, conflict_cnt);
    end
    model_reset();
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL areset_first got=%b want=001", req_ready); end
    cycle();
    req_valid = '0;
    n_cmp++; if (waddr !== 5'd7 || we !== 1'b1) begin n_bad++; $display("FAIL areset_write got=%b/%0d want=1/7", we, waddr); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_req(0, 1'b1, 5'd3, 32'h33);
    set_req(1, 1'b1, 5'd4, 32'h44);
    for (int k = 1; k <= 20; k++) begin
      cycle();
      n_cmp++; if (conflict_cnt !== CW'((k < CMAX) ? k : CMAX)) begin
        n_bad++; $display("FAIL sat_cnt[%0d] got=%0d want=%0d", k, conflict_cnt, (k < CMAX) ? k : CMAX);
      end
    end
    n_cmp++; if (conflict_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_final got=%0d want=15", conflict_cnt); end
    req_valid = '0;
  endtask

  task automatic test_random();
    int wait_cnt [N];
    do_reset();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int t = 0; t < 400; t++) begin
      wb_en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || m_gnt[i]) begin
          set_req(i, ($urandom_range(0, 2) != 0), AW'($urandom), $urandom);
          wait_cnt[i] = 0;
        end
      end
      #1;
      n_cmp++; if (req_ready !== model_grant()) begin
        n_bad++; $display("FAIL rand_ready[%0d] got=%b want=%b", t, req_ready, model_grant());
      end
      cycle();
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !m_gnt[i] && wb_en) wait_cnt[i]++;
        if (wait_cnt[i] >= N) begin
          n_bad++; $display("FAIL rand_starve req=%0d waited=%0d", i, wait_cnt[i]);
          wait_cnt[i] = 0;
        end
      end
      n_cmp++; if (we !== m_we || waddr !== m_waddr || wdata !== m_wdata || conflict_cnt !== CW'(m_cnt)) begin
        n_bad++; $display("FAIL rand_out[%0d] got=%b/%0d/%h/%0d want=%b/%0d/%h/%0d",
                          t, we, waddr, wdata, conflict_cnt, m_we, m_waddr, m_wdata, m_cnt);
      end
    end
    req_valid = '0;
  endtask

  initial begin
    rst       = 1'b0;
    wb_en     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_r0();
    test_wb_en();
    test_async_reset();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
